// File: rtl/core_pkg.sv
// -----------------------------------------------------------------------------
// core_pkg
// Shared core constants, memory-control codes and the store-unit state type.
//
// Contents:
//   DATA_WIDTH         core data bus width (32 or 64)
//   MEM_CTRL_WIDTH     width of the memory-control code carried from EXE
//   ADDR_OFFSET_WIDTH  byte-offset bits within one data bus word
//   MEM_NOP/MEM_WB/MEM_WH/MEM_WW/MEM_WD  memory-control codes (stores)
//   store_state_t      IDLE / REQ / WAIT_ACK
// -----------------------------------------------------------------------------
package core_pkg;

    localparam int DATA_WIDTH        = 32;
    localparam int MEM_CTRL_WIDTH    = 4;
    localparam int ADDR_OFFSET_WIDTH = $clog2(DATA_WIDTH / 8);

    // Codes below 4'h8 belong to loads / no-op and are not stores.
    localparam logic [MEM_CTRL_WIDTH-1:0] MEM_NOP = 4'h0;
    localparam logic [MEM_CTRL_WIDTH-1:0] MEM_WB  = 4'h8;
    localparam logic [MEM_CTRL_WIDTH-1:0] MEM_WH  = 4'h9;
    localparam logic [MEM_CTRL_WIDTH-1:0] MEM_WW  = 4'hA;
    localparam logic [MEM_CTRL_WIDTH-1:0] MEM_WD  = 4'hB;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_ACK = 2'd2
    } store_state_t;

endpackage : core_pkg

// File: rtl/store_align.sv
// -----------------------------------------------------------------------------
// store_align
// Combinational store formatter: replicates the right-aligned store data
// across all byte lanes, builds the byte enables for the addressed lanes and
// flags misaligned or unsupported store codes.
//
// Ports:
//   i_off          byte offset of the store within the bus word
//   i_ctrl         store width code (MEM_WB/MEM_WH/MEM_WW/MEM_WD)
//   i_data         right-aligned store data
//   o_data         lane-replicated write data
//   o_be           byte enables
//   o_misalign     offset not a multiple of the access size
//   o_unsupported  code is not a store this bus width can perform
// -----------------------------------------------------------------------------
module store_align
    import core_pkg::*;
#(
    parameter int DATA_WIDTH = core_pkg::DATA_WIDTH,
    localparam int BE_W      = DATA_WIDTH / 8,
    localparam int OFF_W     = $clog2(BE_W)
) (
    input  logic [OFF_W-1:0]          i_off,
    input  logic [MEM_CTRL_WIDTH-1:0] i_ctrl,
    input  logic [DATA_WIDTH-1:0]     i_data,
    output logic [DATA_WIDTH-1:0]     o_data,
    output logic [BE_W-1:0]           o_be,
    output logic                      o_misalign,
    output logic                      o_unsupported
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // one unassigned, which would otherwise infer a latch.
        o_data        = '0;
        o_be          = '0;
        o_misalign    = 1'b0;
        o_unsupported = 1'b0;
        case (i_ctrl)
            MEM_WB: begin
                o_data = {BE_W{i_data[7:0]}};
                o_be   = BE_W'(1) << i_off;
            end
            MEM_WH: begin
                o_data     = {(BE_W/2){i_data[15:0]}};
                o_be       = BE_W'(2'b11) << i_off;
                o_misalign = i_off[0];
            end
            MEM_WW: begin
                o_data     = {(BE_W/4){i_data[31:0]}};
                o_be       = BE_W'(4'hF) << i_off;
                o_misalign = |i_off[1:0];
            end
            MEM_WD: begin
                // A doubleword only exists on a 64-bit bus.
                if (DATA_WIDTH == 64) begin
                    o_data     = i_data;
                    o_be       = '1;
                    o_misalign = |i_off;
                end else begin
                    o_unsupported = 1'b1;
                end
            end
            default: o_unsupported = 1'b1;
        endcase
    end

endmodule : store_align

// File: rtl/store_unit.sv
// -----------------------------------------------------------------------------
// store_unit
// Data-memory write initiator for stores. Accepts one store from EXE, formats
// it into byte lanes and issues a single write on the req/gnt/ack interface,
// holding ready_o low until the write completes.
//
// Optional build macro: STORE_TIMEOUT_EN
//   When defined, WAIT_ACK gives up after TIMEOUT_CYCLES cycles, pulses err_o
//   and returns to IDLE. When undefined, err_o is tied low.
//
// Ports:
//   clk_i, rstn_i   clock, asynchronous active-low reset
//   valid_i/ready_o EXE store handshake (ready_o high only in IDLE)
//   addr_i          store byte address
//   wdata_i         right-aligned store data
//   mem_ctrl_i      store width code
//   d_m_req_o       write request, held until gnt
//   d_m_gnt_i       request accepted by memory
//   d_m_ack_i       write completed
//   d_m_addr_o      word-aligned address
//   d_m_wdata_o     lane-aligned write data
//   d_m_be_o        byte enables
//   done_o          one-cycle pulse, store completed
//   misalign_o      one-cycle pulse, store rejected as misaligned
//   err_o           one-cycle pulse, ack timeout
// -----------------------------------------------------------------------------
module store_unit
    import core_pkg::*;
#(
    parameter int DATA_WIDTH     = core_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH     = DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 64,
    localparam int BE_W          = DATA_WIDTH / 8,
    localparam int OFF_W         = $clog2(BE_W)
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic                      valid_i,
    output logic                      ready_o,
    input  logic [ADDR_WIDTH-1:0]     addr_i,
    input  logic [DATA_WIDTH-1:0]     wdata_i,
    input  logic [MEM_CTRL_WIDTH-1:0] mem_ctrl_i,
    output logic                      d_m_req_o,
    input  logic                      d_m_gnt_i,
    input  logic                      d_m_ack_i,
    output logic [ADDR_WIDTH-1:0]     d_m_addr_o,
    output logic [DATA_WIDTH-1:0]     d_m_wdata_o,
    output logic [BE_W-1:0]           d_m_be_o,
    output logic                      done_o,
    output logic                      misalign_o,
    output logic                      err_o
);

    store_state_t          r_state;
    logic                  r_req;
    logic                  r_done;
    logic                  r_misalign;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [BE_W-1:0]       r_be;

    logic [DATA_WIDTH-1:0] w_lane_data;
    logic [BE_W-1:0]       w_be;
    logic                  w_misalign;
    logic                  w_unsupported;

`ifdef STORE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] r_cnt;
    logic             r_err;
`endif

    store_align #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_align (
        .i_off         (addr_i[OFF_W-1:0]),
        .i_ctrl        (mem_ctrl_i),
        .i_data        (wdata_i),
        .o_data        (w_lane_data),
        .o_be          (w_be),
        .o_misalign    (w_misalign),
        .o_unsupported (w_unsupported)
    );

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state    <= IDLE;
            r_req      <= 1'b0;
            r_done     <= 1'b0;
            r_misalign <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_be       <= '0;
`ifdef STORE_TIMEOUT_EN
            r_cnt      <= '0;
            r_err      <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments throughout so every register
            // samples the pre-edge values; the pulse defaults below are then
            // safely overridden by later assignments in the same edge.
            r_done     <= 1'b0;
            r_misalign <= 1'b0;
`ifdef STORE_TIMEOUT_EN
            r_err      <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    // Unsupported codes are consumed with no request and no pulse.
                    if (valid_i && !w_unsupported) begin
                        if (w_misalign) begin
                            r_misalign <= 1'b1;
                        end else begin
                            r_addr  <= {addr_i[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
                            r_wdata <= w_lane_data;
                            r_be    <= w_be;
                            r_req   <= 1'b1;
                            r_state <= REQ;
                        end
                    end
                end
                REQ: begin
                    // ack without gnt is meaningless here and is ignored.
                    if (d_m_gnt_i) begin
                        r_req <= 1'b0;
                        if (d_m_ack_i) begin
                            r_done  <= 1'b1;
                            r_state <= IDLE;
                        end else begin
                            r_state <= WAIT_ACK;
`ifdef STORE_TIMEOUT_EN
                            r_cnt   <= '0;
`endif
                        end
                    end
                end
                WAIT_ACK: begin
                    if (d_m_ack_i) begin
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end
`ifdef STORE_TIMEOUT_EN
                    else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        r_err   <= 1'b1;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
`endif
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ready_o     = (r_state == IDLE);
    assign d_m_req_o   = r_req;
    assign d_m_addr_o  = r_addr;
    assign d_m_wdata_o = r_wdata;
    assign d_m_be_o    = r_be;
    assign done_o      = r_done;
    assign misalign_o  = r_misalign;
`ifdef STORE_TIMEOUT_EN
    assign err_o       = r_err;
`else
    assign err_o       = 1'b0;
`endif

endmodule : store_unit

// File: tb/tb_store_unit.sv
// -----------------------------------------------------------------------------
// tb_store_unit
// Self-checking bench for store_unit on a 32-bit bus. A table of stores is
// applied in order; each legal store pushes its expected bus beat to a
// scoreboard queue which is popped when d_m_req_o appears. Hand-written
// sequences cover ack in IDLE, reset in WAIT_ACK and (with STORE_TIMEOUT_EN)
// the ack timeout.
// -----------------------------------------------------------------------------
module tb_store_unit;
    import core_pkg::*;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int BW = DW / 8;

    logic                      clk_i = 1'b0;
    logic                      rstn_i;
    logic                      valid_i;
    logic                      ready_o;
    logic [AW-1:0]             addr_i;
    logic [DW-1:0]             wdata_i;
    logic [MEM_CTRL_WIDTH-1:0] mem_ctrl_i;
    logic                      d_m_req_o;
    logic                      d_m_gnt_i;
    logic                      d_m_ack_i;
    logic [AW-1:0]             d_m_addr_o;
    logic [DW-1:0]             d_m_wdata_o;
    logic [BW-1:0]             d_m_be_o;
    logic                      done_o;
    logic                      misalign_o;
    logic                      err_o;

    store_unit #(
        .DATA_WIDTH     (DW),
        .ADDR_WIDTH     (AW),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .mem_ctrl_i  (mem_ctrl_i),
        .d_m_req_o   (d_m_req_o),
        .d_m_gnt_i   (d_m_gnt_i),
        .d_m_ack_i   (d_m_ack_i),
        .d_m_addr_o  (d_m_addr_o),
        .d_m_wdata_o (d_m_wdata_o),
        .d_m_be_o    (d_m_be_o),
        .done_o      (done_o),
        .misalign_o  (misalign_o),
        .err_o       (err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [AW-1:0]             addr;
        logic [DW-1:0]             data;
        logic [MEM_CTRL_WIDTH-1:0] ctrl;
        int                        gnt_dly;
        int                        ack_dly;
        bit                        ack_noise;
        bit                        exp_req;
        bit                        exp_mis;
        logic [AW-1:0]             exp_addr;
        logic [DW-1:0]             exp_wdata;
        logic [BW-1:0]             exp_be;
    } vec_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [BW-1:0] be;
    } beat_t;

    localparam int NV = 11;
    vec_t  vecs [NV];
    beat_t sb_q [$];

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_store(input vec_t v);
        int    n;
        beat_t b;
        n = 0;
        while (!ready_o && n < 50) begin
            step();
            n++;
        end
        check("ready_before_accept", ready_o, 1);
        valid_i    = 1'b1;
        addr_i     = v.addr;
        wdata_i    = v.data;
        mem_ctrl_i = v.ctrl;
        if (v.exp_req) sb_q.push_back('{v.exp_addr, v.exp_wdata, v.exp_be});
        step();
        valid_i = 1'b0;
        check("misalign_pulse", misalign_o, v.exp_mis);
        check("req_after_accept", d_m_req_o, v.exp_req);
        check("ready_after_accept", ready_o, !v.exp_req);
        check("no_done_after_accept", done_o, 0);
        check("no_err", err_o, 0);
        if (!v.exp_req) return;
        if (sb_q.size() == 0) begin
            check("scoreboard_nonempty", 0, 1);
            return;
        end
        b = sb_q.pop_front();
        check("req_addr", d_m_addr_o, b.addr);
        check("req_wdata", d_m_wdata_o, b.wdata);
        check("req_be", d_m_be_o, b.be);
        for (int i = 0; i < v.gnt_dly; i++) begin
            d_m_ack_i = v.ack_noise && (i == 0);
            step();
            d_m_ack_i = 1'b0;
            check("req_held", d_m_req_o, 1);
            check("addr_stable", d_m_addr_o, b.addr);
            check("wdata_stable", d_m_wdata_o, b.wdata);
            check("be_stable", d_m_be_o, b.be);
            check("ready_low_in_req", ready_o, 0);
            check("no_done_in_req", done_o, 0);
        end
        d_m_gnt_i = 1'b1;
        d_m_ack_i = (v.ack_dly == 0);
        step();
        d_m_gnt_i = 1'b0;
        d_m_ack_i = 1'b0;
        check("req_drop_after_gnt", d_m_req_o, 0);
        if (v.ack_dly > 0) begin
            check("no_done_before_ack", done_o, 0);
            check("ready_low_wait_ack", ready_o, 0);
            for (int i = 0; i < v.ack_dly - 1; i++) begin
                step();
                check("ready_low_wait_ack", ready_o, 0);
                check("no_done_before_ack", done_o, 0);
            end
            d_m_ack_i = 1'b1;
            step();
            d_m_ack_i = 1'b0;
        end
        check("done_pulse", done_o, 1);
        check("ready_with_done", ready_o, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        //             addr          data          ctrl    g  a  nz req mis exp_addr      exp_wdata     be
        vecs[0]  = '{32'h0000_1003, 32'h0000_00AB, MEM_WB, 0, 2, 0, 1, 0, 32'h0000_1000, 32'hABAB_ABAB, 4'b1000};
        vecs[1]  = '{32'h0000_2002, 32'h0000_1234, MEM_WH, 3, 1, 1, 1, 0, 32'h0000_2000, 32'h1234_1234, 4'b1100};
        vecs[2]  = '{32'h0000_3001, 32'h0000_0055, MEM_WW, 0, 0, 0, 0, 1, 32'h0,         32'h0,         4'b0000};
        vecs[3]  = '{32'h0000_4000, 32'hDEAD_BEEF, MEM_WW, 0, 0, 0, 1, 0, 32'h0000_4000, 32'hDEAD_BEEF, 4'b1111};
        vecs[4]  = '{32'h0000_4001, 32'h5A5A_5A77, MEM_WB, 0, 0, 0, 1, 0, 32'h0000_4000, 32'h7777_7777, 4'b0010};
        vecs[5]  = '{32'h0000_5001, 32'h0000_1111, MEM_WH, 0, 0, 0, 0, 1, 32'h0,         32'h0,         4'b0000};
        vecs[6]  = '{32'h0000_5000, 32'h1234_5678, MEM_WD, 0, 0, 0, 0, 0, 32'h0,         32'h0,         4'b0000};
        vecs[7]  = '{32'h0000_5000, 32'h1234_5678, MEM_NOP,0, 0, 0, 0, 0, 32'h0,         32'h0,         4'b0000};
        vecs[8]  = '{32'h0000_6000, 32'hFFFF_BEEF, MEM_WH, 1, 1, 0, 1, 0, 32'h0000_6000, 32'hBEEF_BEEF, 4'b0011};
        vecs[9]  = '{32'hABCD_7000, 32'h0000_0001, MEM_WB, 2, 3, 1, 1, 0, 32'hABCD_7000, 32'h0101_0101, 4'b0001};
        vecs[10] = '{32'h0000_7002, 32'h0000_0002, MEM_WW, 0, 0, 0, 0, 1, 32'h0,         32'h0,         4'b0000};

        rstn_i     = 1'b0;
        valid_i    = 1'b0;
        addr_i     = '0;
        wdata_i    = '0;
        mem_ctrl_i = MEM_NOP;
        d_m_gnt_i  = 1'b0;
        d_m_ack_i  = 1'b0;
        step();
        check("rst_req", d_m_req_o, 0);
        check("rst_done", done_o, 0);
        check("rst_misalign", misalign_o, 0);
        check("rst_err", err_o, 0);
        check("rst_addr", d_m_addr_o, 0);
        check("rst_wdata", d_m_wdata_o, 0);
        check("rst_be", d_m_be_o, 0);
        step();
        rstn_i = 1'b1;
        step();
        check("ready_after_reset", ready_o, 1);

        // ack while idle must not produce a completion.
        d_m_ack_i = 1'b1;
        step();
        d_m_ack_i = 1'b0;
        check("idle_ack_no_done", done_o, 0);
        check("idle_ack_no_req", d_m_req_o, 0);
        check("idle_ack_ready", ready_o, 1);

        // Vectors run back to back: each store is offered in the cycle the
        // previous one completes or is rejected.
        for (int i = 0; i < NV; i++) do_store(vecs[i]);
        step();
        check("done_single_pulse", done_o, 0);
        check("misalign_single_pulse", misalign_o, 0);

        // Reset while waiting for ack abandons the store silently.
        valid_i    = 1'b1;
        addr_i     = 32'h0000_8002;
        wdata_i    = 32'h0000_0011;
        mem_ctrl_i = MEM_WB;
        step();
        valid_i = 1'b0;
        check("rst_seq_req", d_m_req_o, 1);
        check("rst_seq_be", d_m_be_o, 4'b0100);
        d_m_gnt_i = 1'b1;
        step();
        d_m_gnt_i = 1'b0;
        check("rst_seq_wait_ack", ready_o, 0);
        #2;
        rstn_i = 1'b0;
        #1;
        check("mid_rst_req", d_m_req_o, 0);
        check("mid_rst_done", done_o, 0);
        check("mid_rst_addr", d_m_addr_o, 0);
        check("mid_rst_be", d_m_be_o, 0);
        check("mid_rst_wdata", d_m_wdata_o, 0);
        step();
        rstn_i = 1'b1;
        step();
        check("ready_after_mid_rst", ready_o, 1);
        d_m_ack_i = 1'b1;
        step();
        d_m_ack_i = 1'b0;
        check("late_ack_no_done", done_o, 0);
        step();
        check("late_ack_no_done2", done_o, 0);

`ifdef STORE_TIMEOUT_EN
        // gnt without ack: err_o after 8 WAIT_ACK cycles.
        valid_i    = 1'b1;
        addr_i     = 32'h0000_9000;
        wdata_i    = 32'hCAFE_F00D;
        mem_ctrl_i = MEM_WW;
        step();
        valid_i   = 1'b0;
        d_m_gnt_i = 1'b1;
        step();
        d_m_gnt_i = 1'b0;
        n = 0;
        while (!err_o && n < 50) begin
            check("no_done_in_timeout", done_o, 0);
            step();
            n++;
        end
        check("timeout_cycles", n, 8);
        check("timeout_err", err_o, 1);
        check("timeout_ready", ready_o, 1);
        check("timeout_no_done", done_o, 0);
        d_m_ack_i = 1'b1;
        step();
        d_m_ack_i = 1'b0;
        check("err_single_pulse", err_o, 0);
        check("timeout_late_ack_no_done", done_o, 0);
`else
        n = 0;
        check("err_tied_low", err_o, 0);
`endif

        check("scoreboard_drained", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_store_unit

// File: doc/store_unit.md
Name: store_unit

Overview:
Data-memory write initiator for stores: the write-side counterpart of the load extraction done at write-back.
- Accepts a store from the EXE stage: address, rs2 data and store width.
- Aligns data to byte lanes, builds byte enables and issues one write on the data-memory req/gnt/ack interface.
- Holds `ready_o` low while a store is outstanding so the pipeline stalls.

Parameters:
DATA_WIDTH, core_pkg::DATA_WIDTH (32 or 64), data bus width.
ADDR_WIDTH, DATA_WIDTH, byte address width.
TIMEOUT_CYCLES, 64, ack timeout in cycles; used only with STORE_TIMEOUT_EN.

Ports:
clk_i  in  1  core clock.
rstn_i  in  1  asynchronous active-low reset.
valid_i  in  1  EXE presents a store this cycle.
ready_o  out  1  unit can accept (high only in IDLE).
addr_i  in  ADDR_WIDTH  byte address from EXE (exe_out).
wdata_i  in  DATA_WIDTH  store data, right-aligned (rs2).
mem_ctrl_i  in  MEM_CTRL_WIDTH  store width code MEM_WB/MEM_WH/MEM_WW/MEM_WD.
d_m_req_o  out  1  write request to data memory.
d_m_gnt_i  in  1  memory accepted the request.
d_m_ack_i  in  1  write completed.
d_m_addr_o  out  ADDR_WIDTH  word-aligned address (low ADDR_OFFSET_WIDTH bits zero).
d_m_wdata_o  out  DATA_WIDTH  lane-aligned write data.
d_m_be_o  out  DATA_WIDTH/8  byte enables.
done_o  out  1  one-cycle pulse: store completed.
misalign_o  out  1  one-cycle pulse: store rejected as misaligned.
err_o  out  1  one-cycle pulse: timeout (STORE_TIMEOUT_EN only, else tied 0).

Behaviour:
- Reset (async, rstn_i=0):
  - State IDLE.
  - d_m_req_o, done_o, misalign_o, err_o = 0.
  - Address/data/be registers = 0.
  - ready_o = 1 once reset is released.
  - Reset mid-transaction abandons the store silently; no done_o.
- States:
  - IDLE → REQ on accepted legal aligned store.
  - REQ → WAIT_ACK on gnt without ack.
  - REQ → IDLE on gnt with ack in the same cycle.
  - WAIT_ACK → IDLE on ack.
- Accept = valid_i && ready_o in IDLE. On accept, the formatted addr/wdata/be are registered.
- d_m_req_o is registered. It rises the cycle after accept and stays high with stable addr/wdata/be until gnt is sampled.
- d_m_req_o drops the cycle after gnt.
- done_o pulses in the cycle after ack is sampled. ready_o returns high in that same cycle.
- ack is ignored in IDLE; ack while in REQ without gnt is ignored.
- Formatting, with off = addr_i[ADDR_OFFSET_WIDTH-1:0]:
  - WB: be = 1 << off; data byte replicated across all lanes.
  - WH: be = 2'b11 << off; data halfword replicated.
  - WW: be = 4'hF << off; data word replicated.
  - WD (64-bit only): be = all ones.
- Alignment: WH needs off[0]=0; WW needs off[1:0]=0; WD needs off=0.
- Misaligned accept: no request, misalign_o pulses the next cycle, state stays IDLE.
- Unsupported code (a non-store code, or WD when DATA_WIDTH=32): accept is consumed, no request, no pulse.
- Back-to-back: a new store can be accepted in the cycle ready_o is high after done_o. Minimum spacing is accept→req (1) + gnt + ack.

Optional Feature:
Macro STORE_TIMEOUT_EN.
- With it: a counter starts at 0 on entering WAIT_ACK and increments each cycle.
  - If it reaches TIMEOUT_CYCLES-1 without ack: err_o pulses one cycle, state returns to IDLE, no done_o.
  - A late ack arriving in IDLE is ignored.
- Without it: WAIT_ACK waits indefinitely, err_o tied to 0, no counter logic.

Decomposition:
- core_pkg additions: MEM_WB, MEM_WH, MEM_WW, MEM_WD store codes; typedef enum store_state_t {IDLE, REQ, WAIT_ACK}.
- Existing core_pkg constants reused: DATA_WIDTH, MEM_CTRL_WIDTH, ADDR_OFFSET_WIDTH.
- One natural combinational sub-module, store_align: addr offset, width code and data in; lane data, be, misalign and unsupported flags out. store_unit holds the FSM, registers and timeout counter.

Test Plan:
- DATA_WIDTH=32, SB addr 0x1003 data 0xAB, gnt immediate, ack 2 cycles later → req the cycle after accept; addr 0x1000, be 4'b1000, wdata[31:24]=0xAB; done_o one pulse; ready_o low from accept until done.
- SH addr 0x2002 data 0x1234, gnt delayed 3 cycles → req held with stable addr 0x2000, be 4'b1100, wdata[31:16]=0x1234; req drops after gnt.
- SW addr 0x3001 → misalign_o pulse next cycle; req never asserted; ready_o stays 1.
- SW addr 0x4000 data 0xDEADBEEF, gnt and ack in the same cycle → be 4'hF, done_o next cycle; second store accepted the following cycle.
- Reset asserted while in WAIT_ACK → outputs 0 immediately; after release ready_o=1; a late ack produces no done_o.
- STORE_TIMEOUT_EN, TIMEOUT_CYCLES=8, gnt but no ack → err_o pulse after 8 WAIT_ACK cycles, IDLE, ready_o=1.
